usart_rx_byte: RTL and testbench
================================

# usart_rx_byte

Serial-to-parallel front end of the USART receive path. Samples the asynchronous `rx` line (8 data bits, no parity, 1 stop bit, LSB first) and writes each correctly framed byte into the receive FIFO with a one-cycle `wrreq` pulse. The command decoder drains that FIFO on the read side. The block also flags framing errors and bytes lost to a full FIFO.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud): clock cycles per bit period. Legal range is 4 or more.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial input; idle level is high.
- `fifo_full`  in  1  full flag from the receive FIFO write side.
- `data_out`  out  8  received byte; valid while `wrreq`=1 and held until the next write.
- `wrreq`  out  1  FIFO write strobe, one-cycle pulse per accepted byte.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  sticky flag: a good byte was dropped because `fifo_full`=1. Cleared only by `rst`.

## Operation
- **Input synchronizer:** `rx` passes through two flops (both reset to 1). All decisions use the second flop, `rx_s`.
- **Counters:** bit-period counter `cnt`, width ceil(log2(CLKS_PER_BIT)). Bit index `idx` is 3 bits. Data shift register is 8 bits.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- **IDLE:** on `rx_s`=0, set `cnt`=0 and go to START.
- **START:** count up to `CLKS_PER_BIT/2 - 1` (integer division).
  - If `rx_s`=0 at that count: go to DATA, `cnt`=0, `idx`=0.
  - Otherwise: glitch, return to IDLE with no output.
- **DATA:** at `cnt`=CLKS_PER_BIT-1, shift `rx_s` into bit 7 with a right shift, so the first bit received ends in bit 0.
  - Clear `cnt` and increment `idx`.
  - After the sample at `idx`=7, go to STOP.
- **STOP:** at `cnt`=CLKS_PER_BIT-1, sample `rx_s`:
  - `rx_s`=1 and `fifo_full`=0: load `data_out` with the shift register, pulse `wrreq`, go to IDLE.
  - `rx_s`=1 and `fifo_full`=1: no write, set `overrun`=1, go to IDLE. `data_out` is unchanged.
  - `rx_s`=0: pulse `frame_err`, no write, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. A held-low break therefore produces exactly one `frame_err`.
- **Stop-bit timing:** the FSM returns to IDLE at mid-stop-bit. A start edge arriving immediately after the stop bit is detected with no lost byte.
- **`fifo_full` sampling:** `fifo_full` is sampled only in the STOP sample cycle. Its value at all other times is ignored.
- **Reset mid-frame:** the frame is abandoned.
  - FSM goes to IDLE; counters, shift register and synchronizer are reinitialised.
  - All outputs return to their reset values.
  - No partial write ever occurs.

## Timing
- **Reset values:** `data_out`=8'h00, `wrreq`=0, `frame_err`=0, `overrun`=0.
- **Reference edge T0:** the clock edge at which IDLE first sees `rx_s`=0. `rx_s` lags the pin by 2 cycles.
- **Sample edges:** let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT.
  - Start bit: T0+H.
  - Data bit i (i = 0..7): T0+H+(i+1)·N.
  - Stop bit: T0+H+9·N.
- **Output edges:** `wrreq`, `data_out` and `frame_err` are registered and change at the stop-sample edge. They are high for exactly the following cycle.
- **Consecutive writes:** two `wrreq` pulses are never adjacent. The minimum spacing is 10·N minus jitter from re-synchronising the start edge.
- **Flag independence:** `wrreq` and `frame_err` are never high in the same cycle. `overrun` and `wrreq` can never be set by the same frame.

## Test plan
Unless stated otherwise, tests use CLKS_PER_BIT=8 with a pin-level driver at exactly 8 clocks per bit.
- **Single byte:** frame 0x35 ('5'), `fifo_full`=0 → one `wrreq` pulse with `data_out`=8'h35, `frame_err`=0, `overrun`=0.
- **Back-to-back bytes:** "1234" sent with no idle gap → four `wrreq` pulses carrying 31, 32, 33, 34 in order, each one cycle wide.
- **Start glitch:** `rx` low for 2 cycles, then high → no `wrreq`, FSM back in IDLE. A following frame 0x39 is received correctly.
- **Bad stop bit:** frame 0x41 with stop bit 0, line then held low 40 cycles → exactly one `frame_err` pulse and no `wrreq`. The next valid frame 0x30 after the line returns high is written.
- **FIFO full:** `fifo_full`=1 during frame 0x37 → no `wrreq`, `overrun` rises to 1 and stays there. With `fifo_full`=0, the next frame 0x38 is written while `overrun` remains 1; `rst` clears it.
- **Reset mid-frame:** `rst` asserted during data bit 4 → all outputs at reset values the cycle after. A complete frame 0x32 sent afterwards yields one `wrreq` with 8'h32.

Source files
------------

// File: rtl/usart_rx_byte.sv
// USART receive front end: 8N1 deserializer feeding the RX FIFO write port.
// Flags framing errors and good bytes dropped because the FIFO was full.
module usart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       fifo_full,
  output logic [7:0] data_out,
  output logic       wrreq,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        r_state;
  logic          r_rx_meta, r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_wrreq, r_frame_err, r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_wrreq     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wrreq     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= '0;
            r_state <= START;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (r_cnt == HALF) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid stop bit so a start edge right after it is caught.
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              if (!fifo_full) begin
                r_data  <= r_shift;
                r_wrreq <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (r_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out  = r_data;
  assign wrreq     = r_wrreq;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_usart_rx_byte.sv
// Directed bench for usart_rx_byte at 8 clocks per bit; a monitor logs writes
// and error pulses, and the main sequence compares them to hand-derived values.
module tb_usart_rx_byte;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] data_out;
  logic       wrreq, frame_err, overrun;

  int n_chk = 0;
  int n_err = 0;

  int         wr_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] rxd [0:63];
  logic       prev_wr = 1'b0;
  int         adj_bad = 0;
  int         both_bad = 0;

  usart_rx_byte #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rx(rx), .fifo_full(fifo_full),
    .data_out(data_out), .wrreq(wrreq), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrreq) begin
      if (wr_cnt < 64) rxd[wr_cnt] = data_out;
      wr_cnt = wr_cnt + 1;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (wrreq && prev_wr) adj_bad = adj_bad + 1;
    if (wrreq && frame_err) both_bad = both_bad + 1;
    prev_wr = wrreq;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    repeat (N) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop);
  endtask

  task automatic idle(input int cyc);
    rx = 1'b1;
    repeat (cyc) @(negedge clk);
  endtask

  int base;
  logic [7:0] msg [0:3];

  initial begin
    msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 32'h00);
    chk("rst_wrreq", {31'd0, wrreq}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Single byte
    base = wr_cnt;
    send_frame(8'h35, 1'b1);
    idle(20);
    chk("single_cnt", wr_cnt - base, 1);
    chk("single_data", {24'd0, rxd[base]}, 32'h35);
    chk("single_ferr", fe_cnt, 0);
    chk("single_ovr", {31'd0, overrun}, 32'd0);

    // Back-to-back "1234"
    base = wr_cnt;
    for (int k = 0; k < 4; k++) send_frame(msg[k], 1'b1);
    idle(20);
    chk("b2b_cnt", wr_cnt - base, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("b2b_data%0d", k), {24'd0, rxd[base + k]}, {24'd0, msg[k]});

    // Start glitch
    base = wr_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    chk("glitch_cnt", wr_cnt - base, 0);
    send_frame(8'h39, 1'b1);
    idle(20);
    chk("glitch_next_cnt", wr_cnt - base, 1);
    chk("glitch_next_data", {24'd0, rxd[base]}, 32'h39);

    // Bad stop bit followed by a long break
    base = wr_cnt;
    send_frame(8'h41, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(20);
    chk("ferr_cnt", fe_cnt, 1);
    chk("ferr_nowr", wr_cnt - base, 0);
    send_frame(8'h30, 1'b1);
    idle(20);
    chk("ferr_next_cnt", wr_cnt - base, 1);
    chk("ferr_next_data", {24'd0, rxd[base]}, 32'h30);
    chk("ferr_total", fe_cnt, 1);

    // FIFO full drops byte and sets sticky overrun
    base = wr_cnt;
    fifo_full = 1'b1;
    send_frame(8'h37, 1'b1);
    idle(20);
    chk("full_nowr", wr_cnt - base, 0);
    chk("full_ovr", {31'd0, overrun}, 32'd1);
    chk("full_data_held", {24'd0, data_out}, 32'h30);
    fifo_full = 1'b0;
    send_frame(8'h38, 1'b1);
    idle(20);
    chk("full_next_cnt", wr_cnt - base, 1);
    chk("full_next_data", {24'd0, rxd[base]}, 32'h38);
    chk("full_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset during data bit 4 clears outputs, including overrun
    base = wr_cnt;
    bit_period(1'b0);
    bit_period(1'b0); bit_period(1'b1); bit_period(1'b0); bit_period(1'b0);
    rx = 1'b1;
    repeat (N / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data", {24'd0, data_out}, 32'h00);
    chk("midrst_wrreq", {31'd0, wrreq}, 32'd0);
    chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
    chk("midrst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(30);
    chk("midrst_nowr", wr_cnt - base, 0);
    send_frame(8'h32, 1'b1);
    idle(20);
    chk("midrst_next_cnt", wr_cnt - base, 1);
    chk("midrst_next_data", {24'd0, rxd[base]}, 32'h32);

    chk("no_adjacent_wr", adj_bad, 0);
    chk("no_wr_with_ferr", both_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
